// File: rtl/Common.sv
// Shared types and constants for the data-RAM path: response owner encoding and RAM depth.
package Common;

  typedef enum logic [1:0] {OwnerNone, OwnerCpu, OwnerVid} ram_owner_e;

  localparam int RAM_WORDS = 36*125*64/4;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: video has priority, a consecutive-grant counter bounds CPU starvation,
// and the one-cycle-late read word is routed back to whichever requester issued the access.
module ram_arbiter
  import Common::*;
#(
  parameter int ADDR_W  = 17,
  parameter int VID_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [31:0]       cpu_req_wdata,
  input  logic [3:0]        cpu_req_be,
  output logic              cpu_rsp_valid,
  output logic [31:0]       cpu_rsp_rdata,
  input  logic              vid_req_valid,
  output logic              vid_req_ready,
  input  logic [ADDR_W-1:0] vid_req_addr,
  output logic              vid_rsp_valid,
  output logic [31:0]       vid_rsp_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int                CNT_W   = (VID_MAX < 1) ? 1 : $clog2(VID_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(VID_MAX);

  // Handshake: a request transfers in the cycle where its valid and ready are both high;
  // requesters hold valid and payload stable until that cycle, and at most one ready is high.
  logic             grant_vid;
  logic             grant_cpu;
  logic             cpu_starved;
  logic [CNT_W-1:0] vid_cnt_q, vid_cnt_d;
  ram_owner_e       rsp_owner_q, rsp_owner_d;
  logic             rsp_is_write_q, rsp_is_write_d;

  always_comb begin
    cpu_starved = cpu_req_valid && (vid_cnt_q == CNT_MAX);
    grant_vid   = !rst && vid_req_valid && !cpu_starved;
    grant_cpu   = !rst && cpu_req_valid && !grant_vid;
  end

  // The counter only tracks video grants that actually delayed a waiting CPU request.
  always_comb begin
    vid_cnt_d = vid_cnt_q;
    if (!cpu_req_valid || grant_cpu) begin
      vid_cnt_d = '0;
    end else if (grant_vid && (vid_cnt_q != CNT_MAX)) begin
      vid_cnt_d = vid_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    cpu_req_ready  = grant_cpu;
    vid_req_ready  = grant_vid;
    ram_en         = grant_cpu || grant_vid;
    ram_addr       = '0;
    ram_we         = 4'b0000;
    ram_wdata      = 32'h0;
    rsp_owner_d    = OwnerNone;
    rsp_is_write_d = 1'b0;
    if (grant_cpu) begin
      ram_addr       = cpu_req_addr;
      rsp_owner_d    = OwnerCpu;
      rsp_is_write_d = cpu_req_write;
      if (cpu_req_write) begin
        ram_we    = cpu_req_be;
        ram_wdata = cpu_req_wdata;
      end
    end else if (grant_vid) begin
      ram_addr    = vid_req_addr;
      rsp_owner_d = OwnerVid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_cnt_q      <= '0;
      rsp_owner_q    <= OwnerNone;
      rsp_is_write_q <= 1'b0;
    end else begin
      vid_cnt_q      <= vid_cnt_d;
      rsp_owner_q    <= rsp_owner_d;
      rsp_is_write_q <= rsp_is_write_d;
    end
  end

  // Store acknowledges carry no data; the non-owner always sees zeros.
  always_comb begin
    cpu_rsp_valid = (rsp_owner_q == OwnerCpu);
    vid_rsp_valid = (rsp_owner_q == OwnerVid);
    cpu_rsp_rdata = (cpu_rsp_valid && !rsp_is_write_q) ? ram_rdata : 32'h0;
    vid_rsp_rdata = vid_rsp_valid ? ram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small read-first registered RAM model on the RAM port.
module tb_ram_arbiter;

  localparam int ADDR_W  = 17;
  localparam int VID_MAX = 4;

  logic              clk;
  logic              rst;
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_write;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [31:0]       cpu_req_wdata;
  logic [3:0]        cpu_req_be;
  logic              cpu_rsp_valid;
  logic [31:0]       cpu_rsp_rdata;
  logic              vid_req_valid;
  logic              vid_req_ready;
  logic [ADDR_W-1:0] vid_req_addr;
  logic              vid_rsp_valid;
  logic [31:0]       vid_rsp_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_W(ADDR_W), .VID_MAX(VID_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .vid_req_valid(vid_req_valid), .vid_req_ready(vid_req_ready),
    .vid_req_addr(vid_req_addr),
    .vid_rsp_valid(vid_rsp_valid), .vid_rsp_rdata(vid_rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read-first port, 256 words are plenty for this bench
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // driver tasks
  task automatic cpu_drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    cpu_req_valid = v;
    cpu_req_write = w;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    cpu_req_be    = be;
  endtask

  task automatic vid_drive(input logic v, input logic [ADDR_W-1:0] a);
    vid_req_valid = v;
    vid_req_addr  = a;
  endtask

  task automatic cpu_store(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, a, d, 4'hF);
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    // both requesters valid while reset is held: nothing may be granted
    @(negedge clk);
    rst = 1'b1;
    cpu_drive(1'b1, 1'b0, 17'h5, 32'h0, 4'hF);
    vid_drive(1'b1, 17'h3);
    #1;
    checks++;
    if (cpu_req_ready !== 1'b0 || vid_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got cpu=%b vid=%b exp 0/0", cpu_req_ready, vid_req_ready);
    end
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 4'h0 || ram_addr !== '0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_ram got en=%b we=%h addr=%h wd=%h exp 0", ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if (cpu_rsp_valid !== 1'b0 || vid_rsp_valid !== 1'b0 || cpu_rsp_rdata !== 32'h0 || vid_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp got cv=%b vv=%b cd=%h vd=%h exp 0", cpu_rsp_valid, vid_rsp_valid, cpu_rsp_rdata, vid_rsp_rdata);
    end
    checks++;
    if (dut.vid_cnt_q !== 3'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", dut.vid_cnt_q);
    end
    @(negedge clk);
    rst = 1'b0;
    cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
    // video read issued, then reset rises just before the edge: no response must follow
    vid_drive(1'b1, 17'h0);
    #1;
    checks++;
    if (vid_req_ready !== 1'b1) begin
      errors++; $display("FAIL pre_reset_ready got %b exp 1", vid_req_ready);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (vid_req_ready !== 1'b0 || ram_en !== 1'b0) begin
      errors++; $display("FAIL reset_edge_gate got rdy=%b en=%b exp 0/0", vid_req_ready, ram_en);
    end
    @(posedge clk); #1;
    checks++;
    if (vid_rsp_valid !== 1'b0 || vid_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_edge_rsp got v=%b d=%h exp 0/0", vid_rsp_valid, vid_rsp_rdata);
    end
    @(negedge clk);
    vid_drive(1'b0, '0);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (vid_rsp_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_rsp got vv=%b cv=%b exp 0/0", vid_rsp_valid, cpu_rsp_valid);
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 17'h10, 32'h11223344, 4'hF);
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 17'h10, 32'hDEADBEEF, 4'b0110);
    #1;
    checks++;
    if (cpu_req_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'b0110 ||
        ram_addr !== 17'h10 || ram_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_drive got rdy=%b en=%b we=%b addr=%h wd=%h exp 1/1/0110/10/deadbeef",
                         cpu_req_ready, ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 17'h10, 32'hFFFFFFFF, 4'hF);
    #1;
    checks++;
    if (ram_we !== 4'h0 || ram_wdata !== 32'h0 || ram_en !== 1'b1) begin
      errors++; $display("FAIL load_drive got en=%b we=%h wd=%h exp 1/0/0", ram_en, ram_we, ram_wdata);
    end
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h0 || vid_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL store_ack got v=%b d=%h vv=%b exp 1/0/0", cpu_rsp_valid, cpu_rsp_rdata, vid_rsp_valid);
    end
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
    #1;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h11ADBE44) begin
      errors++; $display("FAIL load_data got v=%b d=%h exp 1/11adbe44", cpu_rsp_valid, cpu_rsp_rdata);
    end
    @(negedge clk); #1;
    checks++;
    if (cpu_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load_pulse got %b exp 0", cpu_rsp_valid);
    end
  endtask

  task automatic test_video_stream();
    for (int i = 0; i < 8; i++) cpu_store(17'(i), 32'hA5000000 | 32'(i * 17));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) vid_drive(1'b1, 17'(i));
      else vid_drive(1'b0, '0);
      #1;
      if (i < 8) begin
        checks++;
        if (vid_req_ready !== 1'b1 || ram_addr !== 17'(i) || dut.vid_cnt_q !== 3'd0) begin
          errors++; $display("FAIL vid_issue[%0d] got rdy=%b addr=%h cnt=%0d exp 1/%h/0",
                             i, vid_req_ready, ram_addr, dut.vid_cnt_q, i);
        end
      end
      if (i > 0) begin
        checks++;
        if (vid_rsp_valid !== 1'b1 || vid_rsp_rdata !== (32'hA5000000 | 32'((i - 1) * 17)) || cpu_rsp_valid !== 1'b0) begin
          errors++; $display("FAIL vid_rsp[%0d] got v=%b d=%h cv=%b exp 1/%h/0", i - 1, vid_rsp_valid,
                             vid_rsp_rdata, cpu_rsp_valid, 32'hA5000000 | 32'((i - 1) * 17));
        end
      end
    end
  endtask

  task automatic test_fairness();
    string exp_seq;
    logic  prev_vid;
    exp_seq  = "VVVVCVVVVC";
    prev_vid = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 10) begin
        cpu_drive(1'b1, 1'b0, 17'h1, 32'h0, 4'h0);
        vid_drive(1'b1, 17'h2);
      end else begin
        cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
        vid_drive(1'b0, '0);
      end
      #1;
      if (k < 10) begin
        byte got;
        got = vid_req_ready ? "V" : (cpu_req_ready ? "C" : "N");
        checks++;
        if (got != exp_seq[k] || (vid_req_ready && cpu_req_ready)) begin
          errors++; $display("FAIL fair_grant[%0d] got %c exp %c", k, got, exp_seq[k]);
        end
        checks++;
        if (dut.vid_cnt_q !== 3'(k % 5)) begin
          errors++; $display("FAIL fair_cnt[%0d] got %0d exp %0d", k, dut.vid_cnt_q, k % 5);
        end
      end
      if (k > 0) begin
        checks++;
        if (vid_rsp_valid !== prev_vid || cpu_rsp_valid !== !prev_vid) begin
          errors++; $display("FAIL fair_rsp[%0d] got vv=%b cv=%b exp vv=%b", k - 1, vid_rsp_valid, cpu_rsp_valid, prev_vid);
        end
      end
      if (k < 10) prev_vid = (exp_seq[k] == "V");
    end
  endtask

  task automatic test_owner_routing();
    cpu_store(17'h20, 32'hAAAA0000);
    cpu_store(17'h21, 32'h0000BBBB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
      vid_drive(1'b0, '0);
      if (i < 4 && (i % 2) == 0) vid_drive(1'b1, 17'h20);
      if (i < 4 && (i % 2) == 1) cpu_drive(1'b1, 1'b0, 17'h21, 32'h0, 4'h0);
      #1;
      if (i > 0 && ((i - 1) % 2) == 0) begin
        checks++;
        if (vid_rsp_valid !== 1'b1 || vid_rsp_rdata !== 32'hAAAA0000 ||
            cpu_rsp_valid !== 1'b0 || cpu_rsp_rdata !== 32'h0) begin
          errors++; $display("FAIL route_vid[%0d] got vv=%b vd=%h cv=%b cd=%h exp 1/aaaa0000/0/0",
                             i, vid_rsp_valid, vid_rsp_rdata, cpu_rsp_valid, cpu_rsp_rdata);
        end
      end
      if (i > 0 && ((i - 1) % 2) == 1) begin
        checks++;
        if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h0000BBBB ||
            vid_rsp_valid !== 1'b0 || vid_rsp_rdata !== 32'h0) begin
          errors++; $display("FAIL route_cpu[%0d] got cv=%b cd=%h vv=%b vd=%h exp 1/0000bbbb/0/0",
                             i, cpu_rsp_valid, cpu_rsp_rdata, vid_rsp_valid, vid_rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_zero_be();
    cpu_store(17'h30, 32'h12345678);
    @(negedge clk);
    cpu_drive(1'b1, 1'b1, 17'h30, 32'hFFFFFFFF, 4'h0);
    #1;
    checks++;
    if (cpu_req_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'h0 || ram_wdata !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL zbe_drive got rdy=%b en=%b we=%h wd=%h exp 1/1/0/ffffffff",
                         cpu_req_ready, ram_en, ram_we, ram_wdata);
    end
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
    #1;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL zbe_ack got v=%b d=%h exp 1/0", cpu_rsp_valid, cpu_rsp_rdata);
    end
    @(negedge clk);
    cpu_drive(1'b1, 1'b0, 17'h30, 32'h0, 4'hF);
    @(negedge clk);
    cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
    #1;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'h12345678) begin
      errors++; $display("FAIL zbe_load got v=%b d=%h exp 1/12345678", cpu_rsp_valid, cpu_rsp_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
    vid_drive(1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_store_load();
    test_video_stream();
    test_fairness();
    test_owner_routing();
    test_zero_be();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
